nav_path_sequencer: RTL and testbench

//  Parametrised record/replay engine for car navigation commands. In record mode it
//  run-length encodes a sampled direction stream into (dir,count) entries in internal RAM;
//  in playback it re-issues each direction for its recorded number of ticks to the servo

---
 rtl/nav_path_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_nav_path_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nav_path_sequencer.sv
// rtl/nav_path_sequencer.sv - run-length record/replay engine for navigation direction streams
// Optional reverse playback (Reverse input, mirrored directions) is enabled by defining NAV_REVERSE_EN.
module nav_path_sequencer #(
  parameter int unsigned           DIR_W    = 3,
  parameter int unsigned           CNT_W    = 14,
  parameter int unsigned           DEPTH    = 256,
  parameter logic [DIR_W-1:0]      IDLE_DIR = '0,
  parameter logic [DIR_W-1:0]      REV_XOR  = DIR_W'(1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tick_i,
  input  logic                       mode_i,
  input  logic                       start_i,
  input  logic                       stop_i,
`ifdef NAV_REVERSE_EN
  input  logic                       reverse_i,
`endif
  input  logic [DIR_W-1:0]           dir_i,
  output logic [DIR_W-1:0]           dir_o,
  output logic                       dir_valid_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     entry_count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_REC, S_FLUSH, S_FETCH, S_PLAY, S_FIN} state_t;

  state_t               state_q, state_d;
  logic [EW-1:0]        entry_cnt_q, entry_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 run_vld_q, run_vld_d;
  logic [DIR_W-1:0]     run_dir_q, run_dir_d;
  logic [CNT_W-1:0]     run_cnt_q, run_cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [CNT_W-1:0]     rem_q, rem_d;
  logic [DIR_W-1:0]     dir_q, dir_d;
  logic                 vld_q, vld_d;
  logic                 rev_q, rev_d;
  logic                 wr_en;

  logic [DIR_W+CNT_W-1:0] mem [DEPTH];
  logic [DIR_W+CNT_W-1:0] rd_q;
  logic [DIR_W-1:0]       rd_dir;
  logic [CNT_W-1:0]       rd_cnt;
  logic [EW-1:0]          last_idx;
  logic                   full;
  logic                   last_entry;

  assign rd_dir     = rd_q[DIR_W+CNT_W-1:CNT_W];
  assign rd_cnt     = rd_q[CNT_W-1:0];
  assign last_idx   = entry_cnt_q - EW'(1);
  assign full       = (entry_cnt_q == EW'(DEPTH));
  assign last_entry = rev_q ? (addr_q == '0) : ({1'b0, addr_q} == last_idx);

  // Read address follows addr_d so the entry is on rd_q during the single FETCH cycle.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[entry_cnt_q[AW-1:0]] <= {run_dir_q, run_cnt_q};
    rd_q <= mem[addr_d];
  end

  always_comb begin
    state_d     = state_q;
    entry_cnt_d = entry_cnt_q;
    ovf_d       = ovf_q;
    run_vld_d   = run_vld_q;
    run_dir_d   = run_dir_q;
    run_cnt_d   = run_cnt_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    dir_d       = dir_q;
    vld_d       = vld_q;
    rev_d       = rev_q;
    wr_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (!mode_i) begin
            state_d     = S_REC;
            entry_cnt_d = '0;
            ovf_d       = 1'b0;
            run_vld_d   = 1'b0;
          end else begin
`ifdef NAV_REVERSE_EN
            rev_d = reverse_i;
`else
            rev_d = 1'b0;
`endif
            state_d = (entry_cnt_q == '0) ? S_FIN : S_FETCH;
            addr_d  = rev_d ? last_idx[AW-1:0] : '0;
          end
        end
      end
      S_REC: begin
        if (stop_i) begin
          state_d = S_FLUSH;
        end else if (tick_i) begin
          if (!run_vld_q) begin
            run_vld_d = 1'b1;
            run_dir_d = dir_i;
            run_cnt_d = CNT_W'(1);
          end else if (dir_i == run_dir_q && run_cnt_q != CNT_MAX) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
          end else if (full) begin
            ovf_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            wr_en       = 1'b1;
            entry_cnt_d = entry_cnt_q + EW'(1);
            run_dir_d   = dir_i;
            run_cnt_d   = CNT_W'(1);
          end
        end
      end
      S_FLUSH: begin
        state_d   = S_FIN;
        run_vld_d = 1'b0;
        if (run_vld_q) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en       = 1'b1;
            entry_cnt_d = entry_cnt_q + EW'(1);
          end
        end
      end
      S_FETCH: begin
        if (stop_i) begin
          state_d = S_FIN;
          dir_d   = IDLE_DIR;
          vld_d   = 1'b0;
        end else begin
          state_d = S_PLAY;
          dir_d   = rd_dir ^ (rev_q ? REV_XOR : '0);
          vld_d   = 1'b1;
          rem_d   = rd_cnt;
        end
      end
      S_PLAY: begin
        if (stop_i) begin
          state_d = S_FIN;
          dir_d   = IDLE_DIR;
          vld_d   = 1'b0;
        end else if (tick_i) begin
          if (rem_q <= CNT_W'(1)) begin
            if (last_entry) begin
              state_d = S_FIN;
              dir_d   = IDLE_DIR;
              vld_d   = 1'b0;
            end else begin
              state_d = S_FETCH;
              addr_d  = rev_q ? addr_q - AW'(1) : addr_q + AW'(1);
            end
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        dir_d   = IDLE_DIR;
        vld_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      entry_cnt_q <= '0;
      ovf_q       <= 1'b0;
      run_vld_q   <= 1'b0;
      run_dir_q   <= '0;
      run_cnt_q   <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      dir_q       <= IDLE_DIR;
      vld_q       <= 1'b0;
      rev_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_cnt_q <= entry_cnt_d;
      ovf_q       <= ovf_d;
      run_vld_q   <= run_vld_d;
      run_dir_q   <= run_dir_d;
      run_cnt_q   <= run_cnt_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      dir_q       <= dir_d;
      vld_q       <= vld_d;
      rev_q       <= rev_d;
    end
  end

  assign dir_o         = dir_q;
  assign dir_valid_o   = vld_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_FIN);
  assign overflow_o    = ovf_q;
  assign entry_count_o = entry_cnt_q;

endmodule

// File: tb/tb_nav_path_sequencer.sv
// tb/tb_nav_path_sequencer.sv - randomized self-checking bench for nav_path_sequencer
// Reverse playback scenarios are included when NAV_REVERSE_EN is defined.
module tb_nav_path_sequencer;
  localparam int DIR_W = 3;
  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic             mode = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             reverse = 1'b0;
  logic [DIR_W-1:0] dir_in = '0;
  logic [DIR_W-1:0] dir_o;
  logic             dir_valid_o, busy_o, done_o, overflow_o;
  logic [2:0]       entry_count_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  int  exp_dir[$];
  int  exp_cnt[$];
  bit  exp_ovf;

  nav_path_sequencer #(.DIR_W(DIR_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .IDLE_DIR(3'd0), .REV_XOR(3'd1)) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .mode_i(mode), .start_i(start), .stop_i(stop),
`ifdef NAV_REVERSE_EN
    .reverse_i(reverse),
`endif
    .dir_i(dir_in), .dir_o(dir_o), .dir_valid_o(dir_valid_o), .busy_o(busy_o),
    .done_o(done_o), .overflow_o(overflow_o), .entry_count_o(entry_count_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (done_o) done_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: a list of (dir,count) runs built directly from the recording rules.
  task automatic model_record(input int dirs[$], input bit drop_last);
    int rd, rc, n_in;
    bit have, halted;
    exp_dir.delete(); exp_cnt.delete();
    exp_ovf = 0; have = 0; halted = 0; rd = 0; rc = 0;
    n_in = drop_last ? dirs.size() - 1 : dirs.size();
    for (int i = 0; i < n_in && !halted; i++) begin
      if (!have) begin
        rd = dirs[i]; rc = 1; have = 1;
      end else if (dirs[i] == rd && rc < CMAX) begin
        rc++;
      end else if (exp_dir.size() == DEPTH) begin
        exp_ovf = 1; halted = 1;
      end else begin
        exp_dir.push_back(rd); exp_cnt.push_back(rc);
        rd = dirs[i]; rc = 1;
      end
    end
    if (!halted && have) begin
      if (exp_dir.size() == DEPTH) exp_ovf = 1;
      else begin exp_dir.push_back(rd); exp_cnt.push_back(rc); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (dir_o !== 3'd0) $display("FAIL reset dir_o got %0d want 0", dir_o); else pass_cnt++;
    total_cnt++; if (dir_valid_o !== 1'b0) $display("FAIL reset dir_valid got %0b want 0", dir_valid_o); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset busy got %0b want 0", busy_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL reset done got %0b want 0", done_o); else pass_cnt++;
    total_cnt++; if (overflow_o !== 1'b0) $display("FAIL reset overflow got %0b want 0", overflow_o); else pass_cnt++;
    total_cnt++; if (entry_count_o !== 3'd0) $display("FAIL reset entry_count got %0d want 0", entry_count_o); else pass_cnt++;
  endtask

  task automatic test_record(input int dirs[$], input bit stop_with_last, input string name);
    model_record(dirs, stop_with_last);
    done_cnt = 0;
    @(negedge clk); mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < dirs.size(); i++) begin
      @(negedge clk);
      dir_in = 3'(dirs[i]); tick = 1'b1;
      if (stop_with_last && i == dirs.size() - 1) stop = 1'b1;
      @(negedge clk); tick = 1'b0; stop = 1'b0;
      dir_in = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    if (!stop_with_last) begin
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
    end
    repeat (4) @(negedge clk);
    total_cnt++; if (entry_count_o !== 3'(exp_dir.size())) $display("FAIL rec_%s entry_count got %0d want %0d", name, entry_count_o, exp_dir.size()); else pass_cnt++;
    total_cnt++; if (overflow_o !== exp_ovf) $display("FAIL rec_%s overflow got %0b want %0b", name, overflow_o, exp_ovf); else pass_cnt++;
    total_cnt++; if (done_cnt !== 1) $display("FAIL rec_%s done_pulses got %0d want 1", name, done_cnt); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL rec_%s busy_after got %0b want 0", name, busy_o); else pass_cnt++;
  endtask

  task automatic test_playback(input bit rev, input bit poke_start, input string name);
    int exp_seq[$];
    int got[$];
    bit timeout, bad_idle, valid_seen;
    exp_seq.delete(); got.delete();
    timeout = 1; bad_idle = 0; valid_seen = 0;
    for (int k = 0; k < exp_dir.size(); k++) begin
      int e;
      e = rev ? exp_dir.size() - 1 - k : k;
      for (int t = 0; t < exp_cnt[e]; t++) exp_seq.push_back(rev ? (exp_dir[e] ^ 1) : exp_dir[e]);
    end
    done_cnt = 0;
    @(negedge clk); mode = 1'b1; reverse = rev; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      tick = 1'b0; start = 1'b0;
      if (!busy_o) begin timeout = 0; break; end
      if (dir_valid_o) valid_seen = 1;
      if (!dir_valid_o && dir_o !== 3'd0) bad_idle = 1;
      if (c % 4 == 2) begin
        tick = 1'b1;
        if (dir_valid_o) got.push_back(int'(dir_o));
      end
      if (poke_start && c == 5) begin start = 1'b1; mode = 1'b0; end
    end
    tick = 1'b0; start = 1'b0; reverse = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (timeout) $display("FAIL play_%s timeout got busy want idle within budget", name); else pass_cnt++;
    total_cnt++; if (got.size() !== exp_seq.size()) $display("FAIL play_%s ticks got %0d want %0d", name, got.size(), exp_seq.size()); else pass_cnt++;
    for (int i = 0; i < got.size() && i < exp_seq.size(); i++) begin
      total_cnt++; if (got[i] !== exp_seq[i]) $display("FAIL play_%s dir[%0d] got %0d want %0d", name, i, got[i], exp_seq[i]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt !== 1) $display("FAIL play_%s done_pulses got %0d want 1", name, done_cnt); else pass_cnt++;
    total_cnt++; if (bad_idle) $display("FAIL play_%s idle_dir got nonzero want 0", name); else pass_cnt++;
    total_cnt++; if (valid_seen !== (exp_dir.size() != 0)) $display("FAIL play_%s valid_seen got %0b want %0b", name, valid_seen, exp_dir.size() != 0); else pass_cnt++;
    total_cnt++; if (entry_count_o !== 3'(exp_dir.size())) $display("FAIL play_%s entry_count got %0d want %0d", name, entry_count_o, exp_dir.size()); else pass_cnt++;
  endtask

  task automatic test_stop_play();
    int ticks;
    bit timeout;
    ticks = 0; timeout = 1;
    done_cnt = 0;
    @(negedge clk); mode = 1'b1; reverse = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      tick = 1'b0;
      if (ticks == 2) begin timeout = 0; break; end
      if (c % 4 == 2) begin tick = 1'b1; ticks++; end
    end
    @(negedge clk);
    total_cnt++; if (timeout) $display("FAIL stop_play reach got timeout want 2 ticks"); else pass_cnt++;
    total_cnt++; if (dir_o !== 3'(exp_dir[0])) $display("FAIL stop_play pre_dir got %0d want %0d", dir_o, exp_dir[0]); else pass_cnt++;
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    total_cnt++; if (dir_o !== 3'd0) $display("FAIL stop_play dir got %0d want 0", dir_o); else pass_cnt++;
    total_cnt++; if (dir_valid_o !== 1'b0) $display("FAIL stop_play valid got %0b want 0", dir_valid_o); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (done_cnt !== 1) $display("FAIL stop_play done_pulses got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (busy_o !== 1'b0) $display("FAIL stop_play busy got %0b want 0", busy_o); else pass_cnt++;
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      int dirs[$];
      int len, cur;
      bit swl;
      dirs.delete();
      len = $urandom_range(1, 12);
      cur = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) < 4) cur = $urandom_range(0, 7);
        dirs.push_back(cur);
      end
      swl = ($urandom_range(0, 3) == 0) && (len > 1);
      test_record(dirs, swl, $sformatf("rand%0d", it));
      test_playback(1'b0, 1'b0, $sformatf("rand%0d", it));
`ifdef NAV_REVERSE_EN
      test_playback(1'b1, 1'b0, $sformatf("rand_rev%0d", it));
`endif
    end
  endtask

  initial begin
    int q[$];
    test_reset();

    q = '{2, 2, 2, 5, 5};
    test_record(q, 1'b0, "basic");
    test_playback(1'b0, 1'b1, "basic");
`ifdef NAV_REVERSE_EN
    test_playback(1'b1, 1'b0, "reverse");
`endif
    test_stop_play();

    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(1);
    test_record(q, 1'b0, "saturate");
    test_playback(1'b0, 1'b0, "saturate");

    q = '{1, 2, 3, 4, 5, 6};
    test_record(q, 1'b0, "overflow");
    test_playback(1'b0, 1'b0, "overflow");

    q = '{1, 2, 3, 4, 5};
    test_record(q, 1'b0, "flush_ovf");

    q = '{3};
    test_record(q, 1'b0, "ovf_clear");

    q = '{4, 4, 6};
    test_record(q, 1'b1, "stop_tick");
    test_playback(1'b0, 1'b0, "stop_tick");

    q.delete();
    test_record(q, 1'b0, "empty");
    test_playback(1'b0, 1'b0, "empty");

    test_random(8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
